// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 control-port responder.
package wm8731_pkg;

    // Transaction progress: address byte, two data bytes, each followed by its ACK slot.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK0,
        ST_BYTE1,
        ST_ACK1,
        ST_BYTE2,
        ST_ACK2,
        ST_IGNORE
    } wm_state_t;

    // Codec register indices.
    localparam logic [3:0] R_LINVOL = 4'd0;
    localparam logic [3:0] R_RINVOL = 4'd1;
    localparam logic [3:0] R_LOUT1V = 4'd2;
    localparam logic [3:0] R_ROUT1V = 4'd3;
    localparam logic [3:0] R_APANA  = 4'd4;
    localparam logic [3:0] R_APDIGI = 4'd5;
    localparam logic [3:0] R_PWR    = 4'd6;
    localparam logic [3:0] R_IFACE  = 4'd7;
    localparam logic [3:0] R_SRATE  = 4'd8;
    localparam logic [3:0] R_ACTIVE = 4'd9;
    localparam logic [3:0] R_RESET  = 4'd15;

    localparam int WM_NUM_REGS = 10;

    // Power-on contents of R0..R9.
    localparam logic [8:0] WM_DEFAULTS [WM_NUM_REGS] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    // 7-bit bus address with CSB tied low.
    localparam logic [6:0] WM_DEV_ADDR = 7'h1A;

endpackage

// File: rtl/wm8731_i2c_responder_sync.sv
// Synchronises raw SCL/SDA and derives clock edges plus START/STOP events.
// Events are combinational on the second synchroniser stage versus a delayed copy,
// so a pin change is acted upon at the third clock edge after it.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda
);

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    // Two-stage synchronisers plus one edge-detect stage; reset to the idle-bus level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= i_sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign o_scl_rise  =  r_scl_s2 & ~r_scl_d;
    assign o_scl_fall  = ~r_scl_s2 &  r_scl_d;
    // SDA may only move while SCL is high at a START or STOP.
    assign o_start_det =  r_scl_s2 & r_scl_d &  r_sda_d & ~r_sda_s2;
    assign o_stop_det  =  r_scl_s2 & r_scl_d & ~r_sda_d &  r_sda_s2;
    assign o_sda       =  r_sda_s2;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 write-only control port: decodes 3-byte writes, ACKs them and holds R0..R9.
module wm8731_i2c_responder
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = WM_DEV_ADDR
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       i2c_SCLK,
    input  logic       i2c_SDAT_in,
    output logic       i2c_SDAT_oe,
    input  logic [3:0] reg_sel,
    output logic [8:0] reg_data,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [8:0] wr_data,
    output wm_state_t  o_dbg_state
);

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    wm_state_t  r_state, w_state_next;
    logic       r_sda_oe, w_oe_next;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;      // first seven bits; the eighth comes straight from the line
    logic [6:0] r_reg_addr;
    logic       r_d8;
    logic [8:0] r_bank [WM_NUM_REGS];
    logic       r_wr_valid;
    logic [3:0] r_wr_addr;
    logic [8:0] r_wr_data;

    logic       w_in_byte, w_shift_en, w_byte_done, w_commit;
    logic       w_idx_ok, w_bank_wr, w_soft_rst;
    logic [7:0] w_byte;
    logic [8:0] w_wdata;

    i2c_line_sync u_sync (
        .i_clk       (clk_clk),
        .i_rst_n     (reset_reset_n),
        .i_scl       (i2c_SCLK),
        .i_sda       (i2c_SDAT_in),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop),
        .o_sda       (w_sda)
    );

    assign w_in_byte   = (r_state == ST_ADDR) || (r_state == ST_BYTE1) || (r_state == ST_BYTE2);
    assign w_shift_en  = w_scl_rise && w_in_byte && !w_start && !w_stop;
    assign w_byte_done = w_shift_en && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift, w_sda};
    assign w_wdata     = {r_d8, w_byte};
    assign w_commit    = w_byte_done && (r_state == ST_BYTE2);
    assign w_idx_ok    = (r_reg_addr[6:4] == 3'b000) && (r_reg_addr[3:0] <= R_ACTIVE);
    assign w_bank_wr   = w_commit && w_idx_ok;
    assign w_soft_rst  = w_commit && (r_reg_addr == {3'b000, R_RESET}) && (w_wdata == 9'd0);

    // Next state and ACK drive; bus events override everything, ACK slots span two SCL falls.
    always_comb begin
        w_state_next = r_state;
        w_oe_next    = r_sda_oe;
        if (w_stop) begin
            w_state_next = ST_IDLE;
            w_oe_next    = 1'b0;
        end else if (w_start) begin
            w_state_next = ST_ADDR;
            w_oe_next    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_byte_done)
                        w_state_next = (w_byte == {DEV_ADDR, 1'b0}) ? ST_ACK0 : ST_IGNORE;
                end
                ST_BYTE1: if (w_byte_done) w_state_next = ST_ACK1;
                ST_BYTE2: if (w_byte_done) w_state_next = ST_ACK2;
                ST_ACK0, ST_ACK1, ST_ACK2: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_oe_next = 1'b1;
                        end else begin
                            w_oe_next    = 1'b0;
                            w_state_next = (r_state == ST_ACK0) ? ST_BYTE1 :
                                           (r_state == ST_ACK1) ? ST_BYTE2 : ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state and registered SDA pull-down.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sda_oe <= w_oe_next;
        end
    end

    // Bit counter, shift register and the register-address / data[8] latch from byte 1.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_reg_addr <= 7'd0;
            r_d8       <= 1'b0;
        end else begin
            if (w_start || w_stop) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= w_byte[6:0];
            end
            if (w_byte_done && (r_state == ST_BYTE1)) begin
                r_reg_addr <= w_byte[7:1];
                r_d8       <= w_byte[0];
            end
        end
    end

    // Commit report: one-cycle pulse, address/data hold until the next commit.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 4'd0;
            r_wr_data  <= 9'd0;
        end else begin
            r_wr_valid <= w_bank_wr || w_soft_rst;
            if (w_bank_wr || w_soft_rst) begin
                r_wr_addr <= w_soft_rst ? R_RESET : r_reg_addr[3:0];
                r_wr_data <= w_wdata;
            end
        end
    end

    // Register bank: defaults on reset or soft reset, single-entry update on a valid commit.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < WM_NUM_REGS; i++) r_bank[i] <= WM_DEFAULTS[i];
        end else if (w_soft_rst) begin
            for (int i = 0; i < WM_NUM_REGS; i++) r_bank[i] <= WM_DEFAULTS[i];
        end else if (w_bank_wr) begin
            for (int i = 0; i < WM_NUM_REGS; i++)
                if (r_reg_addr[3:0] == 4'(i)) r_bank[i] <= w_wdata;
        end
    end

    // Read port; indices without a backing register read as zero.
    always_comb begin
        reg_data = 9'd0;
        for (int i = 0; i < WM_NUM_REGS; i++)
            if (reg_sel == 4'(i)) reg_data = r_bank[i];
    end

    assign i2c_SDAT_oe = r_sda_oe;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Bench for wm8731_i2c_responder: an I2C master drives write transactions on an
// open-drain SDA model; a transaction-level codec model predicts ACKs, commits and bank.
// Handshake: wr_valid is a single-cycle strobe with no back-pressure; wr_addr/wr_data
// are meaningful in the cycle wr_valid is high and hold afterwards.
module tb_wm8731_i2c_responder;
    import wm8731_pkg::*;

    localparam int Q = 8;  // quarter SCL period in clk cycles (SCL period = 32 clk)

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       i2c_SDAT_oe;
    logic [3:0] reg_sel;
    logic [8:0] reg_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [8:0] wr_data;
    wm_state_t  dbg_state;

    assign sda_bus = sda_m & ~i2c_SDAT_oe;  // wired-AND open-drain line

    wm8731_i2c_responder #(.DEV_ADDR(7'h1A)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .i2c_SCLK      (scl_m),
        .i2c_SDAT_in   (sda_bus),
        .i2c_SDAT_oe   (i2c_SDAT_oe),
        .reg_sel       (reg_sel),
        .reg_data      (reg_data),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [8:0] dflt [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                              9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
    logic [8:0] m_bank [10];
    logic [12:0] exp_q[$];  // {addr, data} of predicted commits

    typedef struct {
        logic [3:0] addr;
        logic [8:0] data;
        logic [3:0] sel;
        logic [8:0] rdata;
    } pulse_t;
    pulse_t pulse_log [256];
    int pulse_cnt = 0;  // written only by the monitor
    int pulse_rd  = 0;  // written only by the main process
    int oe_total  = 0;  // written only by the monitor

    logic [7:0] txn_b [4];
    logic [3:0] dut_acks, mdl_acks;
    int oe_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: logs every commit strobe with the read port value seen in that cycle.
    always @(negedge clk) begin
        if (i2c_SDAT_oe) oe_total <= oe_total + 1;
        if (wr_valid) begin
            pulse_log[pulse_cnt % 256] <= '{wr_addr, wr_data, reg_sel, reg_data};
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sda_m = b[7-i]; wait_clk(Q);
            scl_m = 1'b1;   wait_clk(2*Q);
            scl_m = 1'b0;   wait_clk(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack = ~sda_bus;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // ---------------- reference model ----------------
    // Codec rules at transaction level: address 0x34 is ACKed along with the next two
    // bytes; a complete 3-byte write commits to R0..R9 or soft-resets via R15 = 0.
    task automatic model_txn(input int n);
        logic [6:0] idx;
        logic [8:0] data;
        mdl_acks = '0;
        if (n >= 1 && txn_b[0] == 8'h34)
            for (int i = 0; i < n && i < 3; i++) mdl_acks[i] = 1'b1;
        if (mdl_acks[0] && n >= 3) begin
            idx  = txn_b[1][7:1];
            data = {txn_b[1][0], txn_b[2]};
            if (idx < 7'd10) begin
                m_bank[idx] = data;
                exp_q.push_back({idx[3:0], data});
            end else if (idx == 7'd15 && data == 9'd0) begin
                for (int i = 0; i < 10; i++) m_bank[i] = dflt[i];
                exp_q.push_back({4'hF, 9'h000});
            end
        end
    endtask

    task automatic run_txn(input int n);
        logic a;
        dut_acks = '0;
        reg_sel  = txn_b[1][4:1];
        wait_clk(1);
        oe_start = oe_total;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_byte(txn_b[i], a);
            dut_acks[i] = a;
        end
        i2c_stop();
        wait_clk(4);
        model_txn(n);
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_compare(input string tag);
        pulse_t p;
        logic [12:0] e;
        check({tag, "_pulses"}, 32'(pulse_cnt - pulse_rd), 32'(exp_q.size()));
        while (pulse_rd < pulse_cnt && exp_q.size() > 0) begin
            p = pulse_log[pulse_rd % 256];
            pulse_rd++;
            e = exp_q.pop_front();
            check({tag, "_wr"}, {p.addr, p.data}, e);
            if (p.addr < 4'd10 && p.sel == p.addr)
                check({tag, "_rd_at_commit"}, p.rdata, p.data);
        end
        pulse_rd = pulse_cnt;
        exp_q.delete();
    endtask

    task automatic check_bank(input string tag);
        for (int s = 0; s < 16; s++) begin
            reg_sel = 4'(s);
            wait_clk(1);
            check({tag, "_reg"}, reg_data, (s < 10) ? m_bank[s] : 9'd0);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        int         n;
        logic [3:0] acks;
        logic       pulse;
        logic [3:0] waddr;
        logic [8:0] wdata;
    } vec_t;
    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h34, 8'h08, 8'h12, 8'h00, 3, 4'b0111, 1'b1, 4'd4,  9'h012}; // R4=0x012
        vecs[1] = '{8'h36, 8'h08, 8'h55, 8'h00, 3, 4'b0000, 1'b0, 4'd0,  9'h000}; // wrong address
        vecs[2] = '{8'h35, 8'h0E, 8'h42, 8'h00, 3, 4'b0000, 1'b0, 4'd0,  9'h000}; // read request
        vecs[3] = '{8'h34, 8'h0E, 8'h42, 8'h00, 3, 4'b0111, 1'b1, 4'd7,  9'h042}; // R7=0x042
        vecs[4] = '{8'h34, 8'h1E, 8'h00, 8'h00, 3, 4'b0111, 1'b1, 4'd15, 9'h000}; // soft reset
        vecs[5] = '{8'h34, 8'h18, 8'h33, 8'h00, 3, 4'b0111, 1'b0, 4'd0,  9'h000}; // index 12
        vecs[6] = '{8'h34, 8'h28, 8'h44, 8'h00, 3, 4'b0111, 1'b0, 4'd0,  9'h000}; // index 20
        vecs[7] = '{8'h34, 8'h1E, 8'h01, 8'h00, 3, 4'b0111, 1'b0, 4'd0,  9'h000}; // R15 nonzero
        vecs[8] = '{8'h34, 8'h02, 8'h80, 8'h77, 4, 4'b0111, 1'b1, 4'd1,  9'h080}; // extra byte NACKed
        vecs[9] = '{8'h34, 8'h13, 8'hFF, 8'h00, 3, 4'b0111, 1'b1, 4'd9,  9'h1FF}; // data[8]=1

        for (int i = 0; i < 10; i++) m_bank[i] = dflt[i];
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; reg_sel = 4'd0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);

        // reset state
        check("rst_oe", i2c_SDAT_oe, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 9'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_bank("rst");

        // table vectors
        for (int v = 0; v < 10; v++) begin
            txn_b[0] = vecs[v].b0; txn_b[1] = vecs[v].b1;
            txn_b[2] = vecs[v].b2; txn_b[3] = vecs[v].b3;
            run_txn(vecs[v].n);
            check($sformatf("vec%0d_acks", v), dut_acks, vecs[v].acks);
            if (vecs[v].acks == 4'b0000)
                check($sformatf("vec%0d_oe_quiet", v), 32'(oe_total - oe_start), 0);
            check($sformatf("vec%0d_pulse", v), 32'(pulse_cnt - pulse_rd), 32'(vecs[v].pulse));
            if (vecs[v].pulse && pulse_cnt > pulse_rd)
                check($sformatf("vec%0d_wr", v),
                      {pulse_log[pulse_rd % 256].addr, pulse_log[pulse_rd % 256].data},
                      {vecs[v].waddr, vecs[v].wdata});
            sb_compare($sformatf("vec%0d", v));
            check_bank($sformatf("vec%0d", v));
        end

        // STOP right after BYTE1's ACK: nothing commits, FSM back in IDLE
        txn_b[0] = 8'h34; txn_b[1] = 8'h0A; txn_b[2] = 8'h00; txn_b[3] = 8'h00;
        run_txn(2);
        check("abort_acks", dut_acks, 4'b0011);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        sb_compare("abort");
        check_bank("abort");

        // Repeated START mid-BYTE2, then a full write of R1=0x1FF
        begin
            logic a;
            reg_sel = 4'd1;
            i2c_start();
            send_byte(8'h34, a);
            send_byte(8'h04, a);
            send_bits(8'hAA, 3);
            txn_b[0] = 8'h34; txn_b[1] = 8'h03; txn_b[2] = 8'hFF;
            run_txn(3);
            check("rstart_acks", dut_acks, 4'b0111);
            sb_compare("rstart");
            check_bank("rstart");
        end

        // Reset asserted while the ACK is being driven
        begin
            i2c_start();
            send_bits(8'h34, 8);
            sda_m = 1'b1;
            for (int k = 0; k < 40 && !i2c_SDAT_oe; k++) wait_clk(1);
            check("rst_ack_oe_seen", i2c_SDAT_oe, 1'b1);
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_ack_oe_released", i2c_SDAT_oe, 1'b0);
            check("rst_ack_state", 32'(dbg_state), 32'(ST_IDLE));
            check("rst_ack_wr_addr", wr_addr, 4'd0);
            check("rst_ack_wr_data", wr_data, 9'd0);
            for (int i = 0; i < 10; i++) m_bank[i] = dflt[i];
            exp_q.delete();
            wait_clk(3);
            rst_n = 1'b1;
            wait_clk(2);
            i2c_stop();
            pulse_rd = pulse_cnt;
            check_bank("rst_ack");
        end

        // Randomized transactions against the model
        for (int r = 0; r < 20; r++) begin
            logic [6:0] ridx;
            int n;
            ridx = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
            txn_b[0] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'h34;
            txn_b[1] = {ridx, 1'($urandom_range(0, 1))};
            txn_b[2] = 8'($urandom_range(0, 255));
            txn_b[3] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                txn_b[1] = 8'h1E;
                txn_b[2] = 8'h00;
            end
            n = $urandom_range(2, 4);
            run_txn(n);
            check($sformatf("rand%0d_acks", r), dut_acks, mdl_acks);
            sb_compare($sformatf("rand%0d", r));
            check_bank($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
